score_keeper: RTL and testbench

Sequential score and match controller feeding the on-screen score digit renderer. It consumes goal pulses from the ball/collision logic and frame ticks from the VGA timing generator. It maintains the two 4-bit BCD-range scores (0–9) that the digit renderer draws, sequences serve delays, and declares the winner. It is the producing end of the score1/score2 interface.

---
 rtl/pong_score_pkg.sv | 19 +
 rtl/frame_timer.sv | 35 +++
 rtl/score_keeper.sv | 150 +++++++++++++++
 tb/tb_score_keeper.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_score_pkg.sv
// rtl/pong_score_pkg.sv - shared match state, score width and side encodings for the pong score path
package pong_score_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_WAIT = 2'd1,
        PLAY       = 2'd2,
        OVER       = 2'd3
    } state_e;

    localparam int SCORE_W           = 4;
    localparam int FRAME_CNT_W       = 8;
    localparam int DEFAULT_WIN_SCORE = 9;

    // serve_dir / winner encoding, shared with the ball logic
    localparam logic SIDE_P1 = 1'b0;
    localparam logic SIDE_P2 = 1'b1;

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - 8-bit frame tick counter with synchronous clear and terminal-count detect
module frame_timer
    import pong_score_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   tick,
    input  logic [FRAME_CNT_W-1:0] terminal,
    output logic                   done
);

    logic [FRAME_CNT_W-1:0] count_q;
    logic [FRAME_CNT_W-1:0] count_d;

    // done flags the tick that brings the count up to terminal, so the owner can act on that same edge
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + 1'b1;
        end
        done = tick && ((count_q + 1'b1) == terminal);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - pong score/match controller; SCORE_AUTO_RESTART_EN enables timed restart from OVER
module score_keeper
    import pong_score_pkg::*;
#(
    parameter int WIN_SCORE      = DEFAULT_WIN_SCORE,
    parameter int SERVE_FRAMES   = 60,
    parameter int RESTART_FRAMES = 180
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               new_game,
    input  logic               goal_left,
    input  logic               goal_right,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               serve,
    output logic               serve_dir,
    output logic               in_play,
    output logic               game_over,
    output logic               winner
);

    localparam logic [SCORE_W-1:0]     WIN_T     = SCORE_W'(WIN_SCORE);
    localparam logic [FRAME_CNT_W-1:0] SERVE_T   = FRAME_CNT_W'(SERVE_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] RESTART_T = FRAME_CNT_W'(RESTART_FRAMES);

    state_e               state_q, state_d;
    logic [SCORE_W-1:0]   score1_q, score1_d, score2_q, score2_d;
    logic                 serve_q, serve_d, serve_dir_q, serve_dir_d;
    logic                 in_play_q, in_play_d, game_over_q, game_over_d;
    logic                 winner_q, winner_d;
    logic [SCORE_W-1:0]   inc1, inc2;
    logic                 start;
    logic                 timer_tick, timer_clear, timer_done;
    logic [FRAME_CNT_W-1:0] timer_terminal;

    frame_timer u_frame_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .tick     (timer_tick),
        .terminal (timer_terminal),
        .done     (timer_done)
    );

    always_comb begin
        state_d        = state_q;
        score1_d       = score1_q;
        score2_d       = score2_q;
        serve_d        = 1'b0;
        serve_dir_d    = serve_dir_q;
        winner_d       = winner_q;
        start          = 1'b0;
        timer_tick     = 1'b0;
        timer_terminal = SERVE_T;
        inc1           = score1_q + 1'b1;
        inc2           = score2_q + 1'b1;

        case (state_q)
            IDLE: start = new_game;
            SERVE_WAIT: begin
                timer_tick = frame_tick;
                if (timer_done) begin
                    serve_d = 1'b1;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                // simultaneous goals cancel out
                if (goal_right && !goal_left) begin
                    score1_d    = inc1;
                    serve_dir_d = SIDE_P2;
                    if (inc1 == WIN_T) begin
                        state_d  = OVER;
                        winner_d = SIDE_P1;
                    end else begin
                        state_d = SERVE_WAIT;
                    end
                end else if (goal_left && !goal_right) begin
                    score2_d    = inc2;
                    serve_dir_d = SIDE_P1;
                    if (inc2 == WIN_T) begin
                        state_d  = OVER;
                        winner_d = SIDE_P2;
                    end else begin
                        state_d = SERVE_WAIT;
                    end
                end
            end
            OVER: begin
                timer_terminal = RESTART_T;
                start          = new_game;
`ifdef SCORE_AUTO_RESTART_EN
                timer_tick = frame_tick && !new_game;
                if (timer_done) begin
                    score1_d    = '0;
                    score2_d    = '0;
                    serve_dir_d = ~winner_q;
                    state_d     = SERVE_WAIT;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            score1_d    = '0;
            score2_d    = '0;
            serve_dir_d = SIDE_P2;
            state_d     = SERVE_WAIT;
        end

        // every state change restarts the shared timer from zero
        timer_clear = (state_d != state_q);
        in_play_d   = (state_d == PLAY);
        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            score1_q    <= '0;
            score2_q    <= '0;
            serve_q     <= 1'b0;
            serve_dir_q <= SIDE_P2;
            in_play_q   <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= SIDE_P1;
        end else begin
            state_q     <= state_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            serve_q     <= serve_d;
            serve_dir_q <= serve_dir_d;
            in_play_q   <= in_play_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign score1    = score1_q;
    assign score2    = score2_q;
    assign serve     = serve_q;
    assign serve_dir = serve_dir_q;
    assign in_play   = in_play_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - self-checking bench for score_keeper against a behavioural match model
module tb_score_keeper;

    localparam int TB_WIN     = 3;
    localparam int TB_SERVE   = 60;
    localparam int TB_RESTART = 180;

    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_PLAY = 2;
    localparam int P_OVER = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       new_game = 1'b0;
    logic       goal_left = 1'b0;
    logic       goal_right = 1'b0;
    logic [3:0] score1, score2;
    logic       serve, serve_dir, in_play, game_over, winner;

    always #5 clk = ~clk;

    score_keeper #(
        .WIN_SCORE      (TB_WIN),
        .SERVE_FRAMES   (TB_SERVE),
        .RESTART_FRAMES (TB_RESTART)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .new_game   (new_game),
        .goal_left  (goal_left),
        .goal_right (goal_right),
        .score1     (score1),
        .score2     (score2),
        .serve      (serve),
        .serve_dir  (serve_dir),
        .in_play    (in_play),
        .game_over  (game_over),
        .winner     (winner)
    );

    int n_checks = 0;
    int n_errors = 0;

    int         m_phase = P_IDLE;
    int         m_ticks = 0;
    logic [3:0] m_s1 = 4'd0, m_s2 = 4'd0;
    logic       m_serve = 1'b0, m_dir = 1'b1, m_winner = 1'b0;

    task automatic model_start();
        m_s1 = 4'd0; m_s2 = 4'd0; m_dir = 1'b1; m_ticks = 0; m_phase = P_WAIT;
    endtask

    task automatic model_point(input bit p1_scored);
        if (p1_scored) begin m_s1 = m_s1 + 4'd1; m_dir = 1'b1; end
        else begin m_s2 = m_s2 + 4'd1; m_dir = 1'b0; end
        m_ticks = 0;
        if ((p1_scored ? m_s1 : m_s2) == 4'(TB_WIN)) begin
            m_phase = P_OVER; m_winner = p1_scored ? 1'b0 : 1'b1;
        end else begin
            m_phase = P_WAIT;
        end
    endtask

    // one clock: drive inputs, advance the model, sample outputs 1 time unit after the edge
    task automatic step(input logic r, input logic ng, input logic ft, input logic gl, input logic gr);
        reset = r; new_game = ng; frame_tick = ft; goal_left = gl; goal_right = gr;
        m_serve = 1'b0;
        if (r) begin
            m_phase = P_IDLE; m_s1 = 4'd0; m_s2 = 4'd0; m_dir = 1'b1; m_winner = 1'b0; m_ticks = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (ng) model_start();
                P_WAIT: if (ft) begin
                    m_ticks++;
                    if (m_ticks == TB_SERVE) begin m_serve = 1'b1; m_phase = P_PLAY; end
                end
                P_PLAY: if (gr && !gl) model_point(1'b1); else if (gl && !gr) model_point(1'b0);
                P_OVER: if (ng) model_start();
`ifdef SCORE_AUTO_RESTART_EN
                else if (ft) begin
                    m_ticks++;
                    if (m_ticks == TB_RESTART) begin
                        m_s1 = 4'd0; m_s2 = 4'd0; m_dir = !m_winner; m_ticks = 0; m_phase = P_WAIT;
                    end
                end
`endif
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        reset = 1'b0; new_game = 1'b0; frame_tick = 1'b0; goal_left = 1'b0; goal_right = 1'b0;
    endtask

    task automatic serve_up();
        int i;
        i = 0;
        while (m_phase != P_PLAY && i < 1000) begin
            step(1'b0, 1'b0, 1'(i % 2), 1'b0, 1'b0);
            i++;
        end
        if (m_phase != P_PLAY) begin
            n_checks++; n_errors++;
            $display("FAIL serve_up_timeout got phase %0d exp %0d", m_phase, P_PLAY);
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++; if (score1 !== 4'd0 || score2 !== 4'd0) begin n_errors++; $display("FAIL reset_scores got %0d/%0d exp 0/0", score1, score2); end
        n_checks++; if (serve !== 1'b0) begin n_errors++; $display("FAIL reset_serve got %b exp 0", serve); end
        n_checks++; if (serve_dir !== 1'b1) begin n_errors++; $display("FAIL reset_serve_dir got %b exp 1", serve_dir); end
        n_checks++; if (in_play !== 1'b0 || game_over !== 1'b0 || winner !== 1'b0) begin n_errors++; $display("FAIL reset_status got %b%b%b exp 000", in_play, game_over, winner); end
    endtask

    task automatic test_serve();
        int pulses;
        pulses = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (in_play !== 1'b0 || score1 !== 4'd0 || score2 !== 4'd0) begin n_errors++; $display("FAIL start_state got in_play %b scores %0d/%0d exp 0 0/0", in_play, score1, score2); end
        for (int i = 1; i <= TB_SERVE; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            pulses += int'(serve);
            if (i < TB_SERVE) begin
                if (serve !== 1'b0 || in_play !== 1'b0) begin n_checks++; n_errors++; $display("FAIL early_serve got serve %b in_play %b at tick %0d exp 0 0", serve, in_play, i); end
            end
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            pulses += int'(serve);
        end
        n_checks++; if (pulses !== 1) begin n_errors++; $display("FAIL serve_pulse_count got %0d exp 1", pulses); end
        n_checks++; if (in_play !== 1'b1 || serve_dir !== 1'b1) begin n_errors++; $display("FAIL serve_play got in_play %b dir %b exp 1 1", in_play, serve_dir); end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            pulses += int'(serve);
        end
        n_checks++; if (pulses !== 1 || score1 !== m_s1 || score2 !== m_s2) begin n_errors++; $display("FAIL serve_after got pulses %0d scores %0d/%0d exp 1 %0d/%0d", pulses, score1, score2, m_s1, m_s2); end
    endtask

    task automatic test_goal();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (score1 !== 4'd1 || score1 !== m_s1) begin n_errors++; $display("FAIL goal_right_score1 got %0d exp %0d", score1, m_s1); end
        n_checks++; if (in_play !== 1'b0 || serve_dir !== 1'b1) begin n_errors++; $display("FAIL goal_right_status got in_play %b dir %b exp 0 1", in_play, serve_dir); end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++; if (score2 !== 4'd0) begin n_errors++; $display("FAIL goal_in_wait got score2 %0d exp 0", score2); end
        serve_up();
    endtask

    task automatic test_simultaneous();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++; if (score1 !== m_s1 || score2 !== m_s2 || in_play !== 1'b1) begin n_errors++; $display("FAIL both_goals got %0d/%0d in_play %b exp %0d/%0d 1", score1, score2, in_play, m_s1, m_s2); end
    endtask

    task automatic test_win();
        for (int p = 0; p < TB_WIN; p++) begin
            if (p > 0) serve_up();
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        n_checks++; if (game_over !== 1'b1 || winner !== 1'b1 || score2 !== 4'(TB_WIN)) begin n_errors++; $display("FAIL p2_win got over %b winner %b score2 %0d exp 1 1 %0d", game_over, winner, score2, TB_WIN); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++; if (score1 !== m_s1 || score2 !== m_s2 || game_over !== 1'b1) begin n_errors++; $display("FAIL frozen got %0d/%0d over %b exp %0d/%0d 1", score1, score2, game_over, m_s1, m_s2); end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (score1 !== 4'd0 || score2 !== 4'd0 || game_over !== 1'b0 || in_play !== 1'b0) begin n_errors++; $display("FAIL restart got %0d/%0d over %b in_play %b exp 0/0 0 0", score1, score2, game_over, in_play); end
        serve_up();
    endtask

    task automatic test_over_hold();
        for (int p = 0; p < TB_WIN; p++) begin
            if (p > 0) serve_up();
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        n_checks++; if (game_over !== 1'b1 || winner !== 1'b0) begin n_errors++; $display("FAIL p1_win got over %b winner %b exp 1 0", game_over, winner); end
        for (int i = 1; i <= 500; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            if (game_over !== (m_phase == P_OVER) || score1 !== m_s1 || score2 !== m_s2) begin
                n_checks++; n_errors++;
                $display("FAIL over_tick got over %b %0d/%0d exp %b %0d/%0d at tick %0d", game_over, score1, score2, m_phase == P_OVER, m_s1, m_s2, i);
            end
`ifdef SCORE_AUTO_RESTART_EN
            if (i == TB_RESTART) begin
                n_checks++; if (score1 !== 4'd0 || score2 !== 4'd0 || game_over !== 1'b0 || serve_dir !== 1'b1) begin n_errors++; $display("FAIL auto_restart got %0d/%0d over %b dir %b exp 0/0 0 1", score1, score2, game_over, serve_dir); end
            end
`endif
        end
`ifndef SCORE_AUTO_RESTART_EN
        n_checks++; if (game_over !== 1'b1 || score1 !== 4'(TB_WIN)) begin n_errors++; $display("FAIL over_hold got over %b score1 %0d exp 1 %0d", game_over, score1, TB_WIN); end
`else
        n_checks++; if (in_play !== 1'b1 || game_over !== 1'b0) begin n_errors++; $display("FAIL auto_replay got in_play %b over %b exp 1 0", in_play, game_over); end
`endif
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        serve_up(); step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        serve_up(); step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        serve_up(); step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (score1 !== 4'd2 || score2 !== 4'd1) begin n_errors++; $display("FAIL pre_reset got %0d/%0d exp 2/1", score1, score2); end
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++; if (score1 !== 4'd0 || score2 !== 4'd0 || in_play !== 1'b0 || serve_dir !== 1'b1) begin n_errors++; $display("FAIL mid_reset got %0d/%0d in_play %b dir %b exp 0/0 0 1", score1, score2, in_play, serve_dir); end
        for (int i = 0; i < 2 * TB_SERVE; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            pulses += int'(serve);
        end
        n_checks++; if (pulses !== 0 || in_play !== 1'b0) begin n_errors++; $display("FAIL idle_no_serve got pulses %0d in_play %b exp 0 0", pulses, in_play); end
    endtask

    task automatic test_random();
        int shown;
        logic r, ng, ft, gl, gr;
        shown = 0;
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 599) == 0);
            ng = ($urandom_range(0, 39) == 0);
            ft = 1'($urandom_range(0, 1));
            gl = ($urandom_range(0, 15) == 0);
            gr = ($urandom_range(0, 15) == 0);
            step(r, ng, ft, gl, gr);
            n_checks++;
            if (score1 !== m_s1 || score2 !== m_s2 || serve !== m_serve || serve_dir !== m_dir ||
                in_play !== (m_phase == P_PLAY) || game_over !== (m_phase == P_OVER) ||
                (m_phase == P_OVER && winner !== m_winner)) begin
                n_errors++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random_cycle %0d got s %0d/%0d sv %b dir %b play %b over %b win %b exp s %0d/%0d sv %b dir %b play %b over %b win %b",
                             i, score1, score2, serve, serve_dir, in_play, game_over, winner,
                             m_s1, m_s2, m_serve, m_dir, m_phase == P_PLAY, m_phase == P_OVER, m_winner);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_goal();
        test_simultaneous();
        test_win();
        test_over_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
